// File: rtl/output_delta_generator_if.sv
// Stream bundle for the output-layer delta generator: activation beats in, delta beats
// and per-sample prediction out.
interface output_delta_generator_if #(
   parameter int width = 16,
   parameter int lanes = 2,
   parameter int n     = 8,
   parameter int beats = 4
);
   localparam int lw = $clog2(n);
   localparam int bw = (beats > 1) ? $clog2(beats) : 1;

   logic [width*lanes-1:0] act_in_package;
   logic                   act_valid;
   logic                   act_ready;
   logic [lw-1:0]          label;
   logic [width*lanes-1:0] del_out_package;
   logic                   del_valid;
   logic                   del_ready;
   logic [bw-1:0]          del_beat;
   logic                   sample_done;
   logic [lw-1:0]          pred_class;
   logic                   pred_correct;

   modport master (
      output act_in_package, act_valid, label, del_ready,
      input  act_ready, del_out_package, del_valid, del_beat, sample_done,
             pred_class, pred_correct
   );

   modport slave (
      input  act_in_package, act_valid, label, del_ready,
      output act_ready, del_out_package, del_valid, del_beat, sample_done,
             pred_class, pred_correct
   );
endinterface

// File: rtl/output_delta_generator.sv
// Output-layer error stage: del = act - onehot(label), saturated, plus a running argmax
// that reports the predicted class and its correctness per sample.
module output_delta_generator #(
   parameter int n         = 8,
   parameter int z         = 8,
   parameter int fi        = 4,
   parameter int width     = 16,
   parameter int int_bits  = 5,
   parameter int frac_bits = 10
) (
   input  logic                     clk,
   input  logic                     reset,
   output_delta_generator_if.slave  bus
);
   localparam int lanes = z / fi;
   localparam int beats = n * fi / z;
   localparam int lw    = $clog2(n);
   localparam int bw    = (beats > 1) ? $clog2(beats) : 1;
   localparam logic [bw-1:0] last_beat = bw'(beats - 1);
   // 1.0 in fixed point, sized to the width+1 difference word (sign + int + one + frac)
   localparam logic [width:0] one_fx = {{(int_bits + 1){1'b0}}, 1'b1, {frac_bits{1'b0}}};

   logic [bw-1:0]          beat_reg;
   logic [lw-1:0]          label_reg;
   logic [width-1:0]       max_val_reg;
   logic [lw-1:0]          max_idx_reg;
   logic [width*lanes-1:0] del_reg;
   logic                   del_valid_reg;
   logic [bw-1:0]          del_beat_reg;
   logic                   sample_done_reg;
   logic [lw-1:0]          pred_class_reg;
   logic                   pred_correct_reg;

   logic                   xfer;
   logic                   first_beat;
   logic [lw-1:0]          cur_label;
   logic [width*lanes-1:0] sat_pkg;
   logic [width-1:0]       run_val [0:lanes];
   logic [lw-1:0]          run_idx [0:lanes];

   assign bus.act_ready = !del_valid_reg || bus.del_ready;
   assign xfer          = bus.act_valid && bus.act_ready;
   assign first_beat    = (beat_reg == '0);
   assign cur_label     = first_beat ? bus.label : label_reg;

   // Argmax chain restarts from (0, index 0) at the first beat of every sample
   assign run_val[0] = first_beat ? '0 : max_val_reg;
   assign run_idx[0] = first_beat ? '0 : max_idx_reg;

   generate
      for (genvar gi = 0; gi < lanes; gi++) begin : g_lane
         logic [width-1:0] act;
         logic [lw-1:0]    idx;
         logic [width:0]   diff;
         logic [width-1:0] sat;

         assign act  = bus.act_in_package[gi*width +: width];
         assign idx  = lw'(int'(beat_reg) * lanes + gi);
         assign diff = {1'b0, act} - ((idx == cur_label) ? one_fx : '0);

         always_comb begin
            if (!diff[width] && diff[width-1])
               sat = {1'b0, {(width-1){1'b1}}};
            else if (diff[width] && !diff[width-1])
               sat = {1'b1, {(width-1){1'b0}}};
            else
               sat = diff[width-1:0];
         end

         assign sat_pkg[gi*width +: width] = sat;
         // Strict compare keeps the lowest index on ties
         assign run_val[gi+1] = (act > run_val[gi]) ? act : run_val[gi];
         assign run_idx[gi+1] = (act > run_val[gi]) ? idx : run_idx[gi];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) begin
         beat_reg         <= '0;
         label_reg        <= '0;
         max_val_reg      <= '0;
         max_idx_reg      <= '0;
         del_reg          <= '0;
         del_valid_reg    <= 1'b0;
         del_beat_reg     <= '0;
         sample_done_reg  <= 1'b0;
         pred_class_reg   <= '0;
         pred_correct_reg <= 1'b0;
      end else if (xfer) begin
         del_reg         <= sat_pkg;
         del_valid_reg   <= 1'b1;
         del_beat_reg    <= beat_reg;
         sample_done_reg <= (beat_reg == last_beat);
         max_val_reg     <= run_val[lanes];
         max_idx_reg     <= run_idx[lanes];
         if (first_beat)
            label_reg <= bus.label;
         if (beat_reg == last_beat) begin
            beat_reg         <= '0;
            pred_class_reg   <= run_idx[lanes];
            pred_correct_reg <= (run_idx[lanes] == cur_label);
         end else begin
            beat_reg <= beat_reg + 1'b1;
         end
      end else if (bus.del_ready) begin
         del_valid_reg   <= 1'b0;
         sample_done_reg <= 1'b0;
      end
   end

   assign bus.del_out_package = del_reg;
   assign bus.del_valid       = del_valid_reg;
   assign bus.del_beat        = del_beat_reg;
   assign bus.sample_done     = sample_done_reg;
   assign bus.pred_class      = pred_class_reg;
   assign bus.pred_correct    = pred_correct_reg;
endmodule

// File: tb/tb_output_delta_generator.sv
// Randomized and directed bench for output_delta_generator against a per-sample
// behavioural model (whole-sample argmax, integer clamp arithmetic).
module tb_output_delta_generator;
   localparam int N  = 8;
   localparam int Z  = 8;
   localparam int FI = 4;
   localparam int W  = 16;
   localparam int L  = Z / FI;
   localparam int B  = N * FI / Z;

   logic clk;
   logic reset;

   output_delta_generator_if #(.width(W), .lanes(L), .n(N), .beats(B)) bus ();

   output_delta_generator #(
      .n(N), .z(Z), .fi(FI), .width(W), .int_bits(5), .frac_bits(10)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // model state
   bit             exp_valid = 0;
   bit             exp_done = 0;
   int             exp_beat = 0;
   logic [W*L-1:0] exp_pkg = '0;
   int             exp_pred = 0;
   bit             exp_correct = 0;
   int             m_beat = 0;
   int             m_label = 0;
   int             m_acts [N];

   logic [W*L-1:0] got_pkg [B];
   int             got_beat [B];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
      end
   endtask

   function automatic logic [W*L-1:0] pack(input int a [N], input int b);
      logic [W*L-1:0] p;
      p = '0;
      for (int j = 0; j < L; j++) p[j*W +: W] = W'(a[b*L + j]);
      return p;
   endfunction

   task automatic model_step(input bit rst, input bit av, input logic [W*L-1:0] pkg,
                             input int lbl, input bit dr);
      int lbl_use, d, idx, best, bi;
      if (rst) begin
         exp_valid = 0; exp_done = 0; exp_beat = 0; exp_pkg = '0;
         exp_pred = 0; exp_correct = 0; m_beat = 0; m_label = 0;
      end else if (av && (!exp_valid || dr)) begin
         if (m_beat == 0) m_label = lbl;
         lbl_use = m_label;
         for (int j = 0; j < L; j++) begin
            idx = m_beat * L + j;
            m_acts[idx] = int'(pkg[j*W +: W]);
            d = m_acts[idx] - ((idx == lbl_use) ? 1024 : 0);
            if (d > 32767) d = 32767;
            if (d < -32768) d = -32768;
            exp_pkg[j*W +: W] = W'(d);
         end
         exp_valid = 1;
         exp_beat  = m_beat;
         exp_done  = (m_beat == B - 1);
         if (m_beat == B - 1) begin
            best = 0; bi = 0;
            for (int i = 0; i < N; i++)
               if (m_acts[i] > best) begin best = m_acts[i]; bi = i; end
            exp_pred    = bi;
            exp_correct = (bi == lbl_use);
         end
         m_beat = (m_beat + 1) % B;
      end else if (dr) begin
         exp_valid = 0;
         exp_done  = 0;
      end
   endtask

   // One clock: drive at the falling edge, check act_ready, advance model, check outputs.
   task automatic step(input bit rst, input bit av, input logic [W*L-1:0] pkg,
                       input int lbl, input bit dr);
      reset              = rst;
      bus.act_valid      = av;
      bus.act_in_package = pkg;
      bus.label          = 3'(lbl);
      bus.del_ready      = dr;
      #1;
      chk("act_ready", 32'(bus.act_ready), 32'(!exp_valid || dr));
      model_step(rst, av, pkg, lbl, dr);
      @(posedge clk);
      @(negedge clk);
      chk("del_valid",       32'(bus.del_valid),    32'(exp_valid));
      chk("sample_done",     32'(bus.sample_done),  32'(exp_done));
      chk("del_beat",        32'(bus.del_beat),     32'(exp_beat));
      chk("del_out_package", bus.del_out_package,   exp_pkg);
      chk("pred_class",      32'(bus.pred_class),   32'(exp_pred));
      chk("pred_correct",    32'(bus.pred_correct), 32'(exp_correct));
   endtask

   task automatic run_sample(input int lbl, input int a [N], input int stall_beat,
                             input int stall_len);
      for (int b = 0; b < B; b++) begin
         step(0, 1, pack(a, b), lbl, 1);
         got_pkg[b]  = bus.del_out_package;
         got_beat[b] = int'(bus.del_beat);
         if (b == stall_beat) begin
            for (int s = 0; s < stall_len; s++) begin
               step(0, 1, pack(a, (b + 1) % B), lbl, 0);
               chk("stall_beat_hold", 32'(bus.del_beat), 32'(b));
               chk("stall_pkg_hold", bus.del_out_package, got_pkg[b]);
            end
         end
      end
   endtask

   initial begin
      int a [N];
      reset = 1'b1;
      bus.act_valid = 0; bus.act_in_package = '0; bus.label = '0; bus.del_ready = 1;
      @(negedge clk);
      step(1, 0, '0, 0, 1);
      step(1, 0, '0, 0, 1);
      chk("reset_valid", 32'(bus.del_valid), 32'd0);

      // basic sample, label 5
      for (int i = 0; i < N; i++) a[i] = 'h0100;
      a[5] = 'h0380;
      run_sample(5, a, -1, 0);
      chk("t1_beat2_pkg", got_pkg[2], 32'hFF80_0100);
      chk("t1_beat0_pkg", got_pkg[0], 32'h0100_0100);
      chk("t1_done", 32'(bus.sample_done), 32'd1);
      chk("t1_pred", 32'(bus.pred_class), 32'd5);
      chk("t1_correct", 32'(bus.pred_correct), 32'd1);

      // backpressure during beat 1
      for (int i = 0; i < N; i++) a[i] = int'($urandom_range(0, 'h7FFF));
      run_sample(2, a, 1, 3);
      for (int b = 0; b < B; b++) chk("t2_beat_order", 32'(got_beat[b]), 32'(b));

      // saturation boundaries
      for (int i = 0; i < N; i++) a[i] = 'hFFFF;
      a[3] = 0;
      run_sample(3, a, -1, 0);
      chk("t3_beat1_pkg", got_pkg[1], 32'hFC00_7FFF);
      chk("t3_pred", 32'(bus.pred_class), 32'd0);

      // argmax tie, wrong class
      for (int i = 0; i < N; i++) a[i] = 'h0100 + i;
      a[2] = 'h0300; a[6] = 'h0300;
      run_sample(6, a, -1, 0);
      chk("t4_pred", 32'(bus.pred_class), 32'd2);
      chk("t4_correct", 32'(bus.pred_correct), 32'd0);

      // back-to-back samples, labels 1 then 7
      for (int i = 0; i < N; i++) a[i] = int'($urandom_range(0, 'h7FFF));
      run_sample(1, a, -1, 0);
      for (int i = 0; i < N; i++) a[i] = int'($urandom_range(0, 'h7FFF));
      run_sample(7, a, -1, 0);

      // reset mid-sample
      for (int i = 0; i < N; i++) a[i] = 'h0200;
      for (int b = 0; b < 3; b++) step(0, 1, pack(a, b), 4, 1);
      step(1, 0, '0, 0, 1);
      chk("t6_rst_valid", 32'(bus.del_valid), 32'd0);
      chk("t6_rst_pred", 32'(bus.pred_class), 32'd0);
      step(1, 0, '0, 0, 1);
      a[0] = 'h0200; a[1] = 'h0050;
      run_sample(0, a, -1, 0);
      chk("t6_beat0", 32'(got_beat[0]), 32'd0);
      chk("t6_pkg0", got_pkg[0], 32'h0050_FE00);
      chk("t6_pred", 32'(bus.pred_class), 32'd0);

      // randomized traffic
      for (int c = 0; c < 400; c++) begin
         logic [W*L-1:0] p;
         for (int j = 0; j < L; j++)
            p[j*W +: W] = ($urandom_range(0, 7) == 0) ? W'($urandom) : W'($urandom_range(0, 'h7FFF));
         step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0, p,
              int'($urandom_range(0, N - 1)), $urandom_range(0, 3) != 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
